rect_swap_engine: RTL and testbench

RECT_SWAP_ENGINE -- requirements
Module: rect_swap_engine

---
 rtl/rect_swap_engine.sv | 213 +++++++++++++++++++++
 tb/tb_rect_swap_engine.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_swap_engine.sv
// rect_swap_engine: randomized checkerboard-swap engine over a ROWS x COLS
// binary matrix held in flip-flops.
//
// Each attempt draws two distinct rows and two distinct columns from a 32-bit
// Galois LFSR. The four corner cells are complemented when they form an
// alternating 2x2 pattern, which leaves every row and column sum unchanged.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en/wr_row/wr_data  write one matrix row (accepted in IDLE only)
//   rd_row/rd_data  combinational row read from the matrix store
//   start/num_swaps begin a run of num_swaps attempts
//   busy            run in progress (PICK/EVAL)
//   done            one-cycle end-of-run pulse
//   attempt_count   attempts completed in the current/last run
//   swap_count      successful swaps in the current/last run
//
// Optional feature: define RECT_SWAP_STATS_EN to build the swap counter;
// without it swap_count is tied to zero.

module rect_swap_engine #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned CNT_W = 12,
    parameter logic [31:0] SEED  = 32'hACE1_2468,
    localparam int unsigned RW   = (ROWS > 2) ? $clog2(ROWS) : 1,
    localparam int unsigned CW   = (COLS > 2) ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [RW-1:0]    wr_row,
    input  logic [COLS-1:0]  wr_data,
    input  logic [RW-1:0]    rd_row,
    output logic [COLS-1:0]  rd_data,
    input  logic             start,
    input  logic [CNT_W-1:0] num_swaps,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] attempt_count,
    output logic [CNT_W-1:0] swap_count
);

    // Feedback mask for x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form.
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam bit ROWS_P2 = (ROWS == (32'd1 << RW));
    localparam bit COLS_P2 = (COLS == (32'd1 << CW));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PICK = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [COLS-1:0]  r_mat [ROWS];
    logic [31:0]      r_lfsr;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_att;
    logic [RW-1:0]    r_r1;
    logic [RW-1:0]    r_r2;
    logic [CW-1:0]    r_c1;
    logic [CW-1:0]    r_c2;
    logic             r_busy;
    logic             r_done;

    logic [31:0]      w_lfsr_next;
    logic [RW-1:0]    w_r1;
    logic [RW-1:0]    w_r2;
    logic [CW-1:0]    w_c1;
    logic [CW-1:0]    w_c2;
    logic             w_rows_ok;
    logic             w_cols_ok;
    logic             w_wr_ok;
    logic             w_valid;
    logic             w_m11;
    logic             w_m12;
    logic             w_m21;
    logic             w_m22;
    logic             w_flip;
    logic [CNT_W-1:0] w_att_next;

    // Index draw from the current LFSR value.
    assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_MASK : 32'h0);
    assign w_r1 = r_lfsr[RW-1:0];
    assign w_r2 = r_lfsr[2*RW-1:RW];
    assign w_c1 = r_lfsr[2*RW+CW-1:2*RW];
    assign w_c2 = r_lfsr[2*RW+2*CW-1:2*RW+CW];

    // Range checks collapse to constants when the dimension is a power of two.
    if (ROWS_P2) begin : g_rows_p2
        assign w_rows_ok = 1'b1;
        assign w_wr_ok   = 1'b1;
        assign rd_data   = r_mat[rd_row];
    end else begin : g_rows_np2
        assign w_rows_ok = (w_r1 < RW'(ROWS)) && (w_r2 < RW'(ROWS));
        assign w_wr_ok   = (wr_row < RW'(ROWS));
        assign rd_data   = (rd_row < RW'(ROWS)) ? r_mat[rd_row] : '0;
    end

    if (COLS_P2) begin : g_cols_p2
        assign w_cols_ok = 1'b1;
    end else begin : g_cols_np2
        assign w_cols_ok = (w_c1 < CW'(COLS)) && (w_c2 < CW'(COLS));
    end

    assign w_valid = w_rows_ok && w_cols_ok && (w_r1 != w_r2) && (w_c1 != w_c2);

    // Corner cells of the registered draw; an alternating 2x2 pattern flips.
    assign w_m11  = r_mat[r_r1][r_c1];
    assign w_m12  = r_mat[r_r1][r_c2];
    assign w_m21  = r_mat[r_r2][r_c1];
    assign w_m22  = r_mat[r_r2][r_c2];
    assign w_flip = (w_m11 == w_m22) && (w_m12 == w_m21) && (w_m11 != w_m12);

    assign w_att_next = r_att + CNT_W'(1);

    // Control FSM, matrix store, LFSR and attempt counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            for (int i = 0; i < int'(ROWS); i++) begin
                r_mat[i] <= '0;
            end
            r_lfsr <= SEED;
            r_num  <= '0;
            r_att  <= '0;
            r_r1   <= '0;
            r_r2   <= '0;
            r_c1   <= '0;
            r_c2   <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_en && w_wr_ok) begin
                        r_mat[wr_row] <= wr_data;
                    end
                    if (start) begin
                        r_num <= num_swaps;
                        r_att <= '0;
                        if (num_swaps == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_PICK;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_PICK: begin
                    r_lfsr <= w_lfsr_next;
                    if (w_valid) begin
                        r_r1    <= w_r1;
                        r_r2    <= w_r2;
                        r_c1    <= w_c1;
                        r_c2    <= w_c2;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (w_flip) begin
                        r_mat[r_r1][r_c1] <= ~w_m11;
                        r_mat[r_r1][r_c2] <= ~w_m12;
                        r_mat[r_r2][r_c1] <= ~w_m21;
                        r_mat[r_r2][r_c2] <= ~w_m22;
                    end
                    r_att <= w_att_next;
                    if (w_att_next == r_num) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_PICK;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RECT_SWAP_STATS_EN
    logic [CNT_W-1:0] r_swp;

    // Successful-swap counter, cleared when a run is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_swp <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_swp <= '0;
        end else if ((r_state == S_EVAL) && w_flip) begin
            r_swp <= r_swp + CNT_W'(1);
        end
    end

    assign swap_count = r_swp;
`else
    assign swap_count = '0;
`endif

    assign busy          = r_busy;
    assign done          = r_done;
    assign attempt_count = r_att;

endmodule

// File: tb/tb_rect_swap_engine.sv
// Testbench for rect_swap_engine: a 2x2 and a 4x4 instance share clock and
// reset. Runs are predicted by a reference model of the swap process; the
// expected counters are queued at start and checked by a monitor on done.

module tb_rect_swap_engine;

    localparam int unsigned CNT_W = 12;
    localparam logic [31:0] SEED  = 32'hACE1_2468;
`ifdef RECT_SWAP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 2x2 instance
    logic             a_wr_en;
    logic [0:0]       a_wr_row;
    logic [1:0]       a_wr_data;
    logic [0:0]       a_rd_row;
    logic [1:0]       a_rd_data;
    logic             a_start;
    logic [CNT_W-1:0] a_num;
    logic             a_busy;
    logic             a_done;
    logic [CNT_W-1:0] a_att;
    logic [CNT_W-1:0] a_swp;

    // 4x4 instance
    logic             b_wr_en;
    logic [1:0]       b_wr_row;
    logic [3:0]       b_wr_data;
    logic [1:0]       b_rd_row;
    logic [3:0]       b_rd_data;
    logic             b_start;
    logic [CNT_W-1:0] b_num;
    logic             b_busy;
    logic             b_done;
    logic [CNT_W-1:0] b_att;
    logic [CNT_W-1:0] b_swp;

    rect_swap_engine #(.ROWS(2), .COLS(2), .CNT_W(CNT_W), .SEED(SEED)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(a_wr_en), .wr_row(a_wr_row), .wr_data(a_wr_data),
        .rd_row(a_rd_row), .rd_data(a_rd_data),
        .start(a_start), .num_swaps(a_num),
        .busy(a_busy), .done(a_done),
        .attempt_count(a_att), .swap_count(a_swp)
    );

    rect_swap_engine #(.ROWS(4), .COLS(4), .CNT_W(CNT_W), .SEED(SEED)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(b_wr_en), .wr_row(b_wr_row), .wr_data(b_wr_data),
        .rd_row(b_rd_row), .rd_data(b_rd_data),
        .start(b_start), .num_swaps(b_num),
        .busy(b_busy), .done(b_done),
        .attempt_count(b_att), .swap_count(b_swp)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int att;
        int swp;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea;
    exp_t eb;
    int   done_cnt_a = 0;
    int   done_cnt_b = 0;
    bit   prev_done_a = 1'b0;
    bit   prev_done_b = 1'b0;

    // Reference model state: matrix rows per instance and the random source.
    bit [3:0]  mm [2][4];
    bit [31:0] ml [2];

    function automatic void check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // One step of the polynomial x^32 + x^22 + x^2 + x + 1.
    function automatic bit [31:0] rng_step(input bit [31:0] l);
        bit [31:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ ((32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1);
        return n;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 4; r++) mm[k][r] = 4'h0;
            ml[k] = SEED;
        end
    endfunction

    // Plays out n attempts on the model matrix; returns the run's counters.
    task automatic model_run(input int k, input int n, output int att, output int swp);
        int dim, bits, msk;
        int r1, r2, c1, c2;
        bit ok;
        dim  = (k == 0) ? 2 : 4;
        bits = (k == 0) ? 1 : 2;
        msk  = (1 << bits) - 1;
        att  = 0;
        swp  = 0;
        r1 = 0; r2 = 0; c1 = 0; c2 = 0;
        for (int a = 0; a < n; a++) begin
            ok = 1'b0;
            while (!ok) begin
                r1 = int'(ml[k]) & msk;
                r2 = int'(ml[k] >> bits) & msk;
                c1 = int'(ml[k] >> (2 * bits)) & msk;
                c2 = int'(ml[k] >> (3 * bits)) & msk;
                ml[k] = rng_step(ml[k]);
                ok = (r1 < dim) && (r2 < dim) && (c1 < dim) && (c2 < dim) &&
                     (r1 != r2) && (c1 != c2);
            end
            if (mm[k][r1][c1] == mm[k][r2][c2] && mm[k][r1][c2] == mm[k][r2][c1] &&
                mm[k][r1][c1] != mm[k][r1][c2]) begin
                mm[k][r1][c1] = ~mm[k][r1][c1];
                mm[k][r1][c2] = ~mm[k][r1][c2];
                mm[k][r2][c1] = ~mm[k][r2][c1];
                mm[k][r2][c2] = ~mm[k][r2][c2];
                swp++;
            end
            att++;
        end
        if (!STATS) swp = 0;
    endtask

    // Monitor: every done pulse pops one expectation and checks the counters.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_done) begin
                done_cnt_a++;
                check("a_done_width", int'(prev_done_a), 0);
                check("a_pending_runs", q_a.size(), 1);
                if (q_a.size() > 0) begin
                    ea = q_a.pop_front();
                    check("a_attempt_count", int'(a_att), ea.att);
                    check("a_swap_count", int'(a_swp), ea.swp);
                end
            end
            if (b_done) begin
                done_cnt_b++;
                check("b_done_width", int'(prev_done_b), 0);
                check("b_pending_runs", q_b.size(), 1);
                if (q_b.size() > 0) begin
                    eb = q_b.pop_front();
                    check("b_attempt_count", int'(b_att), eb.att);
                    check("b_swap_count", int'(b_swp), eb.swp);
                end
            end
            prev_done_a = a_done;
            prev_done_b = b_done;
        end else begin
            prev_done_a = 1'b0;
            prev_done_b = 1'b0;
        end
    end

    task automatic wr(input int k, input int row, input int data);
        @(negedge clk);
        if (k == 0) begin
            a_wr_en = 1'b1; a_wr_row = 1'(row); a_wr_data = 2'(data);
        end else begin
            b_wr_en = 1'b1; b_wr_row = 2'(row); b_wr_data = 4'(data);
        end
        @(negedge clk);
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    task automatic load(input int k, input int row, input int data);
        wr(k, row, data);
        mm[k][row] = 4'(data & ((k == 0) ? 3 : 15));
    endtask

    task automatic rd(input int k, input int row, output int d);
        if (k == 0) a_rd_row = 1'(row);
        else        b_rd_row = 2'(row);
        #1;
        d = (k == 0) ? int'(a_rd_data) : int'(b_rd_data);
    endtask

    task automatic chk_mat(input int k, input string name);
        int d;
        for (int r = 0; r < ((k == 0) ? 2 : 4); r++) begin
            rd(k, r, d);
            check(name, d, int'(mm[k][r]));
        end
    endtask

    // Issues one run, queues its prediction and waits (bounded) for done.
    task automatic run(input int k, input int n, input bit poke,
                       output int cyc, output bit busy_seen);
        exp_t e;
        int att, swp, bound;
        model_run(k, n, att, swp);
        e.att = att;
        e.swp = swp;
        if (k == 0) q_a.push_back(e);
        else        q_b.push_back(e);
        bound     = n * 40 + 20;
        cyc       = 0;
        busy_seen = 1'b0;
        @(negedge clk);
        if (k == 0) begin a_start = 1'b1; a_num = CNT_W'(n); end
        else        begin b_start = 1'b1; b_num = CNT_W'(n); end
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            a_start = 1'b0;
            b_start = 1'b0;
            b_wr_en = 1'b0;
            if ((k == 0) ? a_busy : b_busy) busy_seen = 1'b1;
            if ((k == 0) ? a_done : b_done) begin
                cyc = i;
                break;
            end
            // Writes while busy must be ignored by the engine.
            if (poke && b_busy && (i % 37 == 3)) begin
                b_wr_en   = 1'b1;
                b_wr_row  = 2'($urandom);
                b_wr_data = 4'($urandom);
            end
        end
        b_wr_en = 1'b0;
        check("run_finished", int'(cyc != 0), 1);
    endtask

    task automatic do_reset(input bit check_now);
        int d;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        if (check_now) begin
            check("rst_b_busy", int'(b_busy), 0);
            check("rst_b_done", int'(b_done), 0);
            check("rst_b_att", int'(b_att), 0);
            check("rst_b_swp", int'(b_swp), 0);
            for (int r = 0; r < 4; r++) begin
                rd(1, r, d);
                check("rst_b_row", d, 0);
            end
        end
        q_a.delete();
        q_b.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  cyc, d, dc0;
        bit  bs;
        bit  [3:0] snap [4];
        int  rsum [4];
        int  csum [4];

        rst_n = 1'b0;
        a_wr_en = 1'b0; a_wr_row = '0; a_wr_data = '0; a_rd_row = '0;
        a_start = 1'b0; a_num = '0;
        b_wr_en = 1'b0; b_wr_row = '0; b_wr_data = '0; b_rd_row = '0;
        b_start = 1'b0; b_num = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state of both instances.
        check("init_a_busy", int'(a_busy), 0);
        check("init_a_done", int'(a_done), 0);
        check("init_a_att", int'(a_att), 0);
        check("init_a_swp", int'(a_swp), 0);
        check("init_b_busy", int'(b_busy), 0);
        check("init_b_done", int'(b_done), 0);
        chk_mat(0, "init_a_mat");
        chk_mat(1, "init_b_mat");

        // 2x2 anti-diagonal: one attempt must swap it.
        load(0, 0, 1);
        load(0, 1, 2);
        dc0 = done_cnt_a;
        run(0, 1, 1'b0, cyc, bs);
        @(negedge clk);
        check("a_n1_done_pulses", done_cnt_a - dc0, 1);
        rd(0, 0, d); check("a_n1_row0", d, 2);
        rd(0, 1, d); check("a_n1_row1", d, 1);
        check("a_n1_att_hold", int'(a_att), 1);
        check("a_n1_swp_hold", int'(a_swp), STATS ? 1 : 0);

        // Two attempts restore the original pattern.
        load(0, 0, 1);
        load(0, 1, 2);
        run(0, 2, 1'b0, cyc, bs);
        rd(0, 0, d); check("a_n2_row0", d, 1);
        rd(0, 1, d); check("a_n2_row1", d, 2);
        check("a_n2_swp", int'(a_swp), STATS ? 2 : 0);

        // Zero attempts: done two cycles after start, never busy.
        run(0, 0, 1'b0, cyc, bs);
        check("a_n0_latency", cyc, 2);
        check("a_n0_busy_seen", int'(bs), 0);
        check("a_n0_att", int'(a_att), 0);
        chk_mat(0, "a_n0_mat");

        // 4x4 all-zero: nothing can swap.
        run(1, 5, 1'b0, cyc, bs);
        @(negedge clk);
        check("b_zero_att", int'(b_att), 5);
        check("b_zero_swp", int'(b_swp), 0);
        chk_mat(1, "b_zero_mat");

        // Random matrices and attempt counts.
        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < 4; r++) load(1, r, int'($urandom_range(0, 15)));
            run(1, int'($urandom_range(1, 60)), 1'b0, cyc, bs);
            chk_mat(1, "b_rand_mat");
        end

        // Reference run from SEED, then an aborted run, then a replay.
        do_reset(1'b0);
        for (int r = 0; r < 4; r++) snap[r] = 4'($urandom);
        for (int r = 0; r < 4; r++) load(1, r, int'(snap[r]));
        run(1, 30, 1'b0, cyc, bs);
        chk_mat(1, "b_ref_mat");
        do_reset(1'b0);
        for (int r = 0; r < 4; r++) load(1, r, int'(snap[r]));
        dc0 = done_cnt_b;
        @(negedge clk);
        b_start = 1'b1;
        b_num   = CNT_W'(30);
        @(negedge clk);
        b_start = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_busy_before", int'(b_busy), 1);
        do_reset(1'b1);
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt_b - dc0, 0);
        for (int r = 0; r < 4; r++) load(1, r, int'(snap[r]));
        run(1, 30, 1'b0, cyc, bs);
        chk_mat(1, "b_replay_mat");

        // Long run with writes attempted while busy; sums must be preserved.
        for (int r = 0; r < 4; r++) load(1, r, int'($urandom_range(0, 15)));
        for (int i = 0; i < 4; i++) begin
            rsum[i] = $countones(mm[1][i]);
            csum[i] = 0;
            for (int r = 0; r < 4; r++) csum[i] += int'(mm[1][r][i]);
        end
        run(1, 4095, 1'b1, cyc, bs);
        chk_mat(1, "b_long_mat");
        for (int r = 0; r < 4; r++) begin
            rd(1, r, d);
            snap[r] = 4'(d);
        end
        for (int i = 0; i < 4; i++) begin
            int cs;
            cs = 0;
            for (int r = 0; r < 4; r++) cs += int'(snap[r][i]);
            check("b_long_row_sum", $countones(snap[i]), rsum[i]);
            check("b_long_col_sum", cs, csum[i]);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
